// File: rtl/car_motion_ctrl.sv
// Car motion controller: steps a one-hot car position one floor at a time toward
// the requested stops, and holds the door open for a programmed time at each stop.
module car_motion_ctrl #(
    parameter int unsigned TRAVEL_TICKS = 32,
    parameter int unsigned DOOR_TICKS   = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ud_mode,
    input  logic [3:0] eff_req,
    input  logic       door_hold,
    output logic [3:0] position,
    output logic [1:0] floor_idx,
    output logic       moving,
    output logic [1:0] dir,
    output logic       door_open,
    output logic       arrive
);

    localparam logic [1:0] DirNone = 2'b00;
    localparam logic [1:0] DirUp   = 2'b01;
    localparam logic [1:0] DirDown = 2'b10;

    localparam logic [7:0] TravelLast = 8'(TRAVEL_TICKS - 1);
    localparam logic [7:0] DoorLast   = 8'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StTravel, StSettle, StDoor} state_e;

    state_e     state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic [1:0] settle_q, settle_d;
    logic [3:0] pos_q, pos_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] dir_q, dir_d;
    logic       arrive_q, arrive_d;
    logic       at_stop;
    logic       at_end;

    assign at_stop = |(eff_req & pos_q);
    assign at_end  = pos_q[0] | pos_q[3];

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        settle_d = settle_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        arrive_d = 1'b0;
        case (state_q)
            StIdle: begin
                // A stop at the current floor wins over any departure.
                if (at_stop) begin
                    state_d = StDoor;
                    tick_d  = '0;
                    dir_d   = DirNone;
                end else if (ud_mode == DirUp && !pos_q[3]) begin
                    state_d = StTravel;
                    dir_d   = DirUp;
                    tick_d  = '0;
                end else if (ud_mode == DirDown && !pos_q[0]) begin
                    state_d = StTravel;
                    dir_d   = DirDown;
                    tick_d  = '0;
                end
            end
            StTravel: begin
                if (tick_q == TravelLast) begin
                    pos_d    = (dir_q == DirUp) ? {pos_q[2:0], 1'b0} : {1'b0, pos_q[3:1]};
                    arrive_d = 1'b1;
                    state_d  = StSettle;
                    settle_d = '0;
                    tick_d   = '0;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            StSettle: begin
                // Second settle cycle: the request processor has seen the new floor.
                if (settle_q == 2'd1) begin
                    tick_d = '0;
                    if (at_stop || ud_mode != dir_q || at_end) begin
                        state_d = StDoor;
                        dir_d   = DirNone;
                    end else begin
                        state_d = StTravel;
                    end
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            StDoor: begin
                if (door_hold) begin
                    tick_d = '0;
                end else if (tick_q == DoorLast) begin
                    state_d = StIdle;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d = 2'd0;
        unique case (pos_d)
            4'b0001: idx_d = 2'd0;
            4'b0010: idx_d = 2'd1;
            4'b0100: idx_d = 2'd2;
            4'b1000: idx_d = 2'd3;
            default: idx_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            tick_q   <= '0;
            settle_q <= '0;
            pos_q    <= 4'b0001;
            idx_q    <= 2'd0;
            dir_q    <= DirNone;
            arrive_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            settle_q <= settle_d;
            pos_q    <= pos_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            arrive_q <= arrive_d;
        end
    end

    assign position  = pos_q;
    assign floor_idx = idx_q;
    assign moving    = (state_q == StTravel);
    assign dir       = dir_q;
    assign door_open = (state_q == StDoor);
    assign arrive    = arrive_q;

endmodule

// File: doc/car_motion_ctrl.md
# car_motion_ctrl

Car motion controller: consumes the run mode (`ud_mode`) and effective-stop vector (`eff_req`) from the request-processing block and drives the car's one-hot `position`, stepping one floor at a time. It opens the door on each stop and holds it for a programmed time. It sits between the request processor and the floor/door display logic. It runs on the same 32 Hz system clock and feeds `position` back to the request processor.

## Interface
- `TRAVEL_TICKS`, default 32: clock cycles to travel one floor (1 s at 32 Hz); legal range 2..255.
- `DOOR_TICKS`, default 96: clock cycles the door stays open per stop (3 s); legal range 2..255.
- `clk`  input  1  system clock (32 Hz), rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ud_mode`  input  2  run mode from the request processor: 00 stop, 01 up, 10 down, 11 treated as 00.
- `eff_req`  input  4  one-hot-per-floor effective stop requests (bit0 = floor 1).
- `door_hold`  input  1  door-open button; level-sensitive.
- `position`  output  4  one-hot car floor (bit0 = floor 1).
- `floor_idx`  output  2  binary floor index, 0..3, always consistent with `position`.
- `moving`  output  1  high while travelling between floors.
- `dir`  output  2  current travel direction: 00 none, 01 up, 10 down.
- `door_open`  output  1  high while the door is open.
- `arrive`  output  1  one-cycle pulse when the car reaches a new floor.

## Operation
- States: IDLE, TRAVEL, SETTLE, DOOR.
- 8-bit tick counter, shared by TRAVEL and DOOR.
- 2-bit settle counter.
- IDLE:
  - `ud_mode`=01 and `position`!=4'b1000: go to TRAVEL, `dir`=01, counter=0.
  - `ud_mode`=10 and `position`!=4'b0001: go to TRAVEL, `dir`=10.
  - Requests pointing past an end floor are ignored. The car stays in IDLE, with no wrap-around.
  - (`eff_req` & `position`)!=0: go to DOOR. This handles a request at the current floor.
- TRAVEL:
  - Counter increments each cycle.
  - When counter reaches TRAVEL_TICKS-1, `position` shifts one bit in `dir`: left for up, right for down.
  - On that shift: `arrive` pulses, go to SETTLE.
- SETTLE: fixed 2 cycles. This gives the request processor time to see the new `position` and update `ud_mode`/`eff_req`. Decision on the 2nd cycle:
  - (`eff_req` & `position`)!=0, or `ud_mode`!=`dir`, or the car is at an end floor: go to DOOR.
  - Otherwise go back to TRAVEL in the same direction with counter=0.
- DOOR:
  - `door_open`=1, `dir`=00.
  - Counter counts to DOOR_TICKS-1, then go to IDLE.
  - `door_hold`=1 resets the counter to 0 every cycle it is asserted.
- `moving`=1 exactly in TRAVEL. `dir` is held through TRAVEL and SETTLE.
- `ud_mode` changes during TRAVEL are ignored until the floor is reached. The car never reverses or stops between floors.
- `position` is always exactly one-hot. No illegal encoding can be reached.
- `floor_idx` is the binary encode of `position`, registered together with it.

## Timing
- Reset values (asserted asynchronously): state IDLE, `position`=4'b0001, `floor_idx`=0, `moving`=0, `dir`=00, `door_open`=0, `arrive`=0, both counters 0.
- Reset mid-travel or with the door open returns to floor 1 immediately.
- Start latency: first clock edge with a valid `ud_mode` in IDLE enters TRAVEL. `moving` is high from that edge.
- Floor-to-floor: TRAVEL_TICKS cycles in TRAVEL plus 2 in SETTLE. A non-stop pass therefore costs TRAVEL_TICKS+2 cycles per floor.
- `position` and `arrive` update on the same edge.
- Door: exactly DOOR_TICKS cycles of `door_open`, measured from the SETTLE→DOOR edge, extended by `door_hold`.
- IDLE is entered for at least 1 cycle after DOOR before a new departure.
- Simultaneous events:
  - If `ud_mode` is 01 and `eff_req` hits the current floor in IDLE, the door takes priority.
  - `door_hold` has no effect outside DOOR.

## Test plan
Parameters for all scenarios: TRAVEL_TICKS=4, DOOR_TICKS=6.
1. Reset → `position`=0001, `floor_idx`=0, all other outputs 0. Then `ud_mode`=01, `eff_req`=0100 → `arrive` at 0010 after 4 cycles, SETTLE 2, continues. `position`=0100 at cycle 10, `door_open` high for 6 cycles, then IDLE.
2. At floor 4, drive `ud_mode`=01 → car stays in IDLE, `position` stays 1000, `moving`=0. Then `ud_mode`=10, `eff_req`=0001 → floor 1 reached after 3 floors × 6 cycles, door opens.
3. Mid-TRAVEL from floor 1, flip `ud_mode` to 10 → car still arrives at 0010 and stops, since `ud_mode`!=`dir`. Door opens, then departs downward from IDLE.
4. In DOOR, hold `door_hold`=1 for 10 cycles then release → `door_open` lasts 10+6 cycles total.
5. Assert `rst_n`=0 asynchronously mid-TRAVEL between floors 2 and 3 → outputs return to reset values without a clock edge. After release, car idles at 0001.
6. In IDLE at floor 2 with `eff_req`=0010 and `ud_mode`=01 → door opens on the next edge, no travel. Check `position` stays one-hot across a random 2000-cycle `ud_mode`/`eff_req` sequence.
